// File: rtl/lbuf_output_stage.sv
// lbuf_output_stage: line-buffer read addressing, sync re-alignment, border mask and scanline darkening.
// Inputs reach the registered outputs exactly LBUF_RD_LATENCY+3 PCLK cycles later.
module lbuf_output_stage #(
    parameter int LBUF_RD_LATENCY = 2,
    parameter int H_MULT          = 4,
    parameter int V_CTR_MAX       = 4
) (
    input  logic        PCLK,
    input  logic        reset,
    input  logic        HSYNC_in,
    input  logic        VSYNC_in,
    input  logic        DE_in,
    input  logic [8:0]  hcnt_lbuf,
    input  logic [5:0]  vcnt_lbuf,
    input  logic [2:0]  h_ctr,
    input  logic [2:0]  v_ctr,
    input  logic        mask_enable,
    input  logic [1:0]  sl_mode,
    input  logic [3:0]  sl_str,
    input  logic [7:0]  mask_color,
    output logic [14:0] lbuf_rdaddr,
    input  logic [23:0] lbuf_rdata,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        HSYNC_out,
    output logic        VSYNC_out,
    output logic        DE_out
);
    typedef enum logic {WAIT_VS, ACTIVE} state_t;
    localparam logic [2:0] V_LAST = 3'(V_CTR_MAX);
    localparam logic [2:0] H_LAST = 3'(H_MULT - 1);
    // sideband word: {hsync, vsync, de, mask, sl_hit}, idles with syncs deasserted high
    localparam logic [4:0] SB_IDLE = 5'b11000;
    state_t state, state_nxt;
    logic        vs_prev, vs_fall, active, wd_hit;
    logic [21:0] wd_cnt;
    logic [1:0]  mode_l;
    logic [3:0]  str_l;
    logic [7:0]  mask_l;
    logic        sl_hit;
    logic [4:0]  sb [0:LBUF_RD_LATENCY];
    logic [4:0]  sb_end;
    logic [23:0] rgb_sel, p_rgb;
    logic        p_hs, p_vs, p_de;

    function automatic logic [7:0] darken(input logic [7:0] c, input logic [3:0] s);
        logic [12:0] p;
        p = {5'd0, c} * {8'd0, 5'd16 - {1'b0, s}};
        return p[11:4];
    endfunction

    assign vs_fall = vs_prev && !VSYNC_in;
    assign wd_hit  = &wd_cnt;

    always_ff @(posedge PCLK or posedge reset)
        if (reset) state <= WAIT_VS;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (state == WAIT_VS && vs_fall) state_nxt = ACTIVE;
        if (state == ACTIVE && wd_hit) state_nxt = WAIT_VS;
    end

    always_comb active = (state == ACTIVE);

    // Config only moves at frame start so a frame is never rendered with mixed settings
    always_ff @(posedge PCLK or posedge reset)
        if (reset) begin
            vs_prev <= 1'b1;
            mode_l  <= '0;
            str_l   <= '0;
            mask_l  <= '0;
            wd_cnt  <= '0;
        end else begin
            vs_prev <= VSYNC_in;
            wd_cnt  <= (active && !VSYNC_in && !wd_hit) ? wd_cnt + 22'd1 : 22'd0;
            if (vs_fall) begin
                mode_l <= sl_mode;
                str_l  <= sl_str;
                mask_l <= mask_color;
            end
        end

    assign sl_hit = (mode_l[0] && v_ctr == V_LAST) || (mode_l[1] && h_ctr == H_LAST);

    always_ff @(posedge PCLK or posedge reset)
        if (reset) begin
            lbuf_rdaddr <= '0;
            for (int i = 0; i <= LBUF_RD_LATENCY; i++) sb[i] <= SB_IDLE;
        end else begin
            lbuf_rdaddr <= {vcnt_lbuf, hcnt_lbuf};
            sb[0] <= {HSYNC_in, VSYNC_in, DE_in && active, mask_enable, sl_hit};
            for (int i = 1; i <= LBUF_RD_LATENCY; i++) sb[i] <= sb[i-1];
        end

    assign sb_end = sb[LBUF_RD_LATENCY];

    always_comb
        rgb_sel = !sb_end[2] ? 24'd0 :
                  sb_end[1]  ? {3{mask_l}} :
                  sb_end[0]  ? {darken(lbuf_rdata[23:16], str_l),
                                darken(lbuf_rdata[15:8], str_l),
                                darken(lbuf_rdata[7:0], str_l)} :
                               lbuf_rdata;

    always_ff @(posedge PCLK or posedge reset)
        if (reset) begin
            p_rgb     <= '0;
            p_hs      <= 1'b1;
            p_vs      <= 1'b1;
            p_de      <= 1'b0;
            R_out     <= '0;
            G_out     <= '0;
            B_out     <= '0;
            HSYNC_out <= 1'b1;
            VSYNC_out <= 1'b1;
            DE_out    <= 1'b0;
        end else begin
            p_rgb     <= rgb_sel;
            p_hs      <= sb_end[4];
            p_vs      <= sb_end[3];
            p_de      <= sb_end[2];
            R_out     <= p_rgb[23:16];
            G_out     <= p_rgb[15:8];
            B_out     <= p_rgb[7:0];
            HSYNC_out <= p_hs;
            VSYNC_out <= p_vs;
            DE_out    <= p_de;
        end
endmodule

// File: tb/tb_lbuf_output_stage.sv
// tb_lbuf_output_stage: directed vector streams with hand-computed colours, plus address and reset sequences.
module tb_lbuf_output_stage;
    typedef struct {
        logic        hs, vs, de, mk;
        logic [2:0]  vc, hc;
        logic [23:0] rd;
        logic        ede;
        logic [23:0] ergb;
    } vec_t;

    logic        PCLK = 1'b0, reset = 1'b1;
    logic        HSYNC_in = 1'b1, VSYNC_in = 1'b1, DE_in = 1'b0, mask_enable = 1'b0;
    logic [8:0]  hcnt_lbuf = '0;
    logic [5:0]  vcnt_lbuf = '0;
    logic [2:0]  h_ctr = '0, v_ctr = '0;
    logic [1:0]  sl_mode = '0;
    logic [3:0]  sl_str = '0;
    logic [7:0]  mask_color = '0;
    logic [14:0] lbuf_rdaddr;
    logic [23:0] lbuf_rdata = '0;
    logic [7:0]  R_out, G_out, B_out;
    logic        HSYNC_out, VSYNC_out, DE_out;
    vec_t        vq[$];
    int          checks = 0, failures = 0;

    lbuf_output_stage #(.LBUF_RD_LATENCY(2), .H_MULT(4), .V_CTR_MAX(4)) dut (
        .PCLK(PCLK), .reset(reset), .HSYNC_in(HSYNC_in), .VSYNC_in(VSYNC_in), .DE_in(DE_in),
        .hcnt_lbuf(hcnt_lbuf), .vcnt_lbuf(vcnt_lbuf), .h_ctr(h_ctr), .v_ctr(v_ctr),
        .mask_enable(mask_enable), .sl_mode(sl_mode), .sl_str(sl_str), .mask_color(mask_color),
        .lbuf_rdaddr(lbuf_rdaddr), .lbuf_rdata(lbuf_rdata), .R_out(R_out), .G_out(G_out),
        .B_out(B_out), .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .DE_out(DE_out)
    );

    always #5 PCLK = ~PCLK;

    function automatic vec_t mk(input logic hs, vs, de, m, input logic [2:0] vc, hc,
                                input logic [23:0] rd, input logic ede, input logic [23:0] ergb);
        vec_t v;
        v.hs = hs; v.vs = vs; v.de = de; v.mk = m; v.vc = vc; v.hc = hc;
        v.rd = rd; v.ede = ede; v.ergb = ergb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one vector per cycle; RAM data follows its address by 3 drive slots and
    // outputs are compared 5 slots after the vector was applied.
    task automatic run_stream();
        int   n;
        vec_t v;
        n = vq.size();
        for (int m = 0; m < n + 5; m++) begin
            @(negedge PCLK);
            if (m >= 5) begin
                v = vq[m-5];
                chk($sformatf("hsync[%0d]", m - 5), {23'd0, HSYNC_out}, {23'd0, v.hs});
                chk($sformatf("vsync[%0d]", m - 5), {23'd0, VSYNC_out}, {23'd0, v.vs});
                chk($sformatf("de[%0d]", m - 5), {23'd0, DE_out}, {23'd0, v.ede});
                chk($sformatf("rgb[%0d]", m - 5), {R_out, G_out, B_out}, v.ergb);
            end
            if (m < n) begin
                v = vq[m];
                HSYNC_in = v.hs; VSYNC_in = v.vs; DE_in = v.de; mask_enable = v.mk;
                v_ctr = v.vc; h_ctr = v.hc;
                hcnt_lbuf = 9'(m); vcnt_lbuf = 6'(m % 40);
            end else begin
                HSYNC_in = 1'b1; VSYNC_in = 1'b1; DE_in = 1'b0; mask_enable = 1'b0;
                v_ctr = '0; h_ctr = '0;
            end
            lbuf_rdata = (m >= 3 && m - 3 < n) ? vq[m-3].rd : 24'd0;
        end
        vq.delete();
    endtask

    initial begin
        repeat (2) @(negedge PCLK);
        chk("rst_rdaddr", {9'd0, lbuf_rdaddr}, 24'd0);
        chk("rst_rgb", {R_out, G_out, B_out}, 24'd0);
        chk("rst_hsync", {23'd0, HSYNC_out}, 24'd1);
        chk("rst_vsync", {23'd0, VSYNC_out}, 24'd1);
        chk("rst_de", {23'd0, DE_out}, 24'd0);
        sl_mode = 2'd1; sl_str = 4'd8; mask_color = 8'h40;
        reset = 1'b0;

        // frame 1: DE before the first VSYNC fall is suppressed, then mask / scanline cases
        vq.push_back(mk(1, 1, 1, 0, 4, 0, 24'hFF8000, 0, 24'h000000));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 24'h123456, 0, 24'h000000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        vq.push_back(mk(1, 1, 1, 1, 0, 0, 24'hFFFFFF, 1, 24'h404040));
        vq.push_back(mk(1, 1, 1, 0, 4, 0, 24'hFF8000, 1, 24'h7F4000));
        vq.push_back(mk(1, 1, 1, 0, 3, 0, 24'hFF8000, 1, 24'hFF8000));
        vq.push_back(mk(1, 1, 1, 0, 4, 3, 24'h123456, 1, 24'h091A2B));
        vq.push_back(mk(1, 1, 1, 0, 2, 3, 24'h123456, 1, 24'h123456));
        vq.push_back(mk(1, 1, 0, 0, 4, 0, 24'hFF8000, 0, 24'h000000));
        vq.push_back(mk(1, 1, 1, 1, 4, 0, 24'hFF8000, 1, 24'h404040));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        run_stream();

        // new strength/mode take effect only after the next VSYNC fall
        sl_mode = 2'd3; sl_str = 4'd15;
        vq.push_back(mk(1, 1, 1, 0, 4, 0, 24'hFFFFFF, 1, 24'h7F7F7F));
        vq.push_back(mk(1, 1, 1, 0, 0, 3, 24'hFFFFFF, 1, 24'hFFFFFF));
        for (int i = 0; i < 4; i++) vq.push_back(mk(1, 1, 0, 0, 0, 0, 24'h0, 0, 24'h0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 24'h000000, 0, 24'h000000));
        vq.push_back(mk(1, 1, 1, 0, 4, 0, 24'hFFFFFF, 1, 24'h0F0F0F));
        vq.push_back(mk(1, 1, 1, 0, 0, 3, 24'hFFFFFF, 1, 24'h0F0F0F));
        vq.push_back(mk(1, 1, 1, 0, 0, 0, 24'hFFFFFF, 1, 24'hFFFFFF));
        vq.push_back(mk(1, 1, 1, 0, 4, 3, 24'h80FF01, 1, 24'h080F00));
        run_stream();

        // sync pass-through with arbitrary patterns
        for (int i = 0; i < 40; i++) begin
            logic hs, vs;
            hs = 1'($urandom);
            vs = (i > 35) ? 1'b1 : 1'($urandom);
            vq.push_back(mk(hs, vs, 0, 0, 0, 0, 24'h0, 0, 24'h0));
        end
        run_stream();

        // read address is a plain concatenation, registered once
        @(negedge PCLK); hcnt_lbuf = 9'h1FF; vcnt_lbuf = 6'd39;
        @(negedge PCLK); chk("addr_max", {9'd0, lbuf_rdaddr}, 24'h004FFF);
        hcnt_lbuf = 9'h000; vcnt_lbuf = 6'd0;
        @(negedge PCLK); chk("addr_wrap", {9'd0, lbuf_rdaddr}, 24'h000000);
        hcnt_lbuf = 9'h0AB; vcnt_lbuf = 6'd5;
        @(negedge PCLK); chk("addr_mid", {9'd0, lbuf_rdaddr}, 24'h000AAB);

        // asynchronous reset mid-line
        HSYNC_in = 1'b0; VSYNC_in = 1'b1; DE_in = 1'b1; mask_enable = 1'b1;
        repeat (6) @(negedge PCLK);
        chk("pre_rst_de", {23'd0, DE_out}, 24'd1);
        chk("pre_rst_hsync", {23'd0, HSYNC_out}, 24'd0);
        chk("pre_rst_rgb", {R_out, G_out, B_out}, 24'h404040);
        #2 reset = 1'b1;
        #1;
        chk("arst_hsync", {23'd0, HSYNC_out}, 24'd1);
        chk("arst_de", {23'd0, DE_out}, 24'd0);
        chk("arst_rgb", {R_out, G_out, B_out}, 24'd0);
        chk("arst_rdaddr", {9'd0, lbuf_rdaddr}, 24'd0);
        @(negedge PCLK); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            chk($sformatf("wait_de[%0d]", i), {23'd0, DE_out}, 24'd0);
            chk($sformatf("wait_rgb[%0d]", i), {R_out, G_out, B_out}, 24'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
